// File: rtl/sevenseg_mux.sv
// sevenseg_mux: four-digit common-anode seven-segment scanner.
// Ports: clk, reset (sync, active-high), d0..d3 BCD digits, tick
// (decimal-point trigger); an/seg/dp active-low registered outputs.
module sevenseg_mux #(
  parameter int REFRESH_DIV = 4,
  parameter int DP_HOLD     = 8,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic       tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = $clog2(DP_HOLD + 1);

  localparam logic [CW-1:0] CNT_MAX =
    CW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DP_LOAD =
    DW'(DP_HOLD);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [3:0][3:0] sh_q,  sh_d;
  logic [DW-1:0]   dpc_q, dpc_d;
  logic [3:0]      an_q,  an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q,  dp_d;

  logic wrap;
  logic frame_end;
  logic z3, z2, z1;
  logic blank;

  // Segment pattern g..a, active-low; 10-15 show a dash.
  function automatic logic [6:0] dec(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap      = (cnt_q == CNT_MAX);
    frame_end = wrap && (sel_q == 2'd3);

    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    sel_d = wrap ? sel_q + 2'd1 : sel_q;

    // Digits are latched together only at the
    // frame boundary so a frame never mixes values.
    sh_d = frame_end ? {d3, d2, d1, d0} : sh_q;

    // A tick reloads even while counting down.
    dpc_d = dpc_q;
    if (tick)
      dpc_d = DP_LOAD;
    else if (dpc_q != '0)
      dpc_d = dpc_q - DW'(1);

    z3 = (sh_q[3] == 4'd0);
    z2 = z3 && (sh_q[2] == 4'd0);
    z1 = z2 && (sh_q[1] == 4'd0);

    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      case (sel_q)
        2'd3:    blank = z3;
        2'd2:    blank = z2;
        2'd1:    blank = z1;
        default: blank = 1'b0;
      endcase
    end

    an_d  = ~(4'b0001 << sel_q);
    seg_d = blank ? SEG_OFF : dec(sh_q[sel_q]);
    dp_d  = ~((sel_q == 2'd0) && (dpc_q != '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= 2'd0;
      sh_q  <= '0;
      dpc_q <= '0;
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      sh_q  <= sh_d;
      dpc_q <= dpc_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// tb_sevenseg_mux: directed bench for sevenseg_mux
// (REFRESH_DIV=4, DP_HOLD=8, BLANK_LZ=1; frame = 16 cycles).
module tb_sevenseg_mux;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] d0, d1, d2, d3;
  logic       tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sevenseg_mux #(
    .REFRESH_DIV(4),
    .DP_HOLD(8),
    .BLANK_LZ(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .d0(d0),
    .d1(d1),
    .d2(d2),
    .d3(d3),
    .tick(tick),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_boundary();
    do step(); while (cyc % 16 != 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick  = 1'b0;
    {d3, d2, d1, d0} = 16'h0000;
    step();
    step();
    checks += 3;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL rst_an got %b exp 1111", an);
    end
    if (seg !== 7'b1111111) begin
      errors++;
      $display("FAIL rst_seg got %b exp 1111111", seg);
    end
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL rst_dp got %b exp 1", dp);
    end
    reset = 1'b0;
    cyc = 0;
    step();
    checks += 2;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL rel_an got %b exp 1110", an);
    end
    if (seg !== 7'b1000000) begin
      errors++;
      $display("FAIL rel_seg got %b exp 1000000", seg);
    end
  endtask

  task automatic test_scan();
    logic [6:0] tbl [4];
    logic [3:0] ea;
    int dig;
    tbl[0] = 7'b1111000;
    tbl[1] = 7'b0011001;
    tbl[2] = 7'b1111111;
    tbl[3] = 7'b1111111;
    {d3, d2, d1, d0} = 16'h0047;
    to_boundary();
    for (int r = 0; r < 16; r++) begin
      step();
      dig = r / 4;
      ea = 4'b1111;
      ea[dig] = 1'b0;
      checks += 3;
      if (an !== ea) begin
        errors++;
        $display("FAIL scan_an r=%0d got %b exp %b",
                 r, an, ea);
      end
      if (seg !== tbl[dig]) begin
        errors++;
        $display("FAIL scan_seg r=%0d got %b exp %b",
                 r, seg, tbl[dig]);
      end
      if (dp !== 1'b1) begin
        errors++;
        $display("FAIL scan_dp r=%0d got %b exp 1",
                 r, dp);
      end
    end
  endtask

  task automatic test_midframe();
    logic [6:0] tbl [4];
    int dig;
    tbl[0] = 7'b1111000;
    tbl[1] = 7'b0011001;
    tbl[2] = 7'b1111111;
    tbl[3] = 7'b1111111;
    for (int r = 1; r <= 16; r++) begin
      if (r == 6) d0 = 4'd2;
      step();
      dig = (r - 1) / 4;
      checks++;
      if (seg !== tbl[dig]) begin
        errors++;
        $display("FAIL mid_old r=%0d got %b exp %b",
                 r, seg, tbl[dig]);
      end
    end
    for (int r = 1; r <= 4; r++) begin
      step();
      checks += 2;
      if (an !== 4'b1110) begin
        errors++;
        $display("FAIL mid_an r=%0d got %b exp 1110",
                 r, an);
      end
      if (seg !== 7'b0100100) begin
        errors++;
        $display("FAIL mid_new r=%0d got %b exp 0100100",
                 r, seg);
      end
    end
  endtask

  task automatic test_dp();
    logic ex;
    to_boundary();
    // Single tick: window ends exactly at r=18.
    for (int r = 1; r <= 32; r++) begin
      tick = (r == 10);
      step();
      tick = 1'b0;
      ex = !(r == 17 || r == 18);
      checks++;
      if (dp !== ex) begin
        errors++;
        $display("FAIL dp_hold r=%0d got %b exp %b",
                 r, dp, ex);
      end
    end
    // Second tick 5 cycles later reloads the hold.
    for (int r = 1; r <= 32; r++) begin
      tick = (r == 7 || r == 12);
      step();
      tick = 1'b0;
      ex = !(r >= 17 && r <= 20);
      checks++;
      if (dp !== ex) begin
        errors++;
        $display("FAIL dp_reload r=%0d got %b exp %b",
                 r, dp, ex);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] tbl [4];
    int dig;
    tbl[0] = 7'b1111001;
    tbl[1] = 7'b0111111;
    tbl[2] = 7'b1111111;
    tbl[3] = 7'b1111111;
    {d3, d2, d1, d0} = 16'h00B1;
    to_boundary();
    for (int r = 0; r < 16; r++) begin
      step();
      dig = r / 4;
      checks++;
      if (seg !== tbl[dig]) begin
        errors++;
        $display("FAIL inv_seg r=%0d got %b exp %b",
                 r, seg, tbl[dig]);
      end
    end
  endtask

  task automatic test_reset_mid();
    to_boundary();
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    checks += 3;
    if (an !== 4'b1111) begin
      errors++;
      $display("FAIL rmid_an got %b exp 1111", an);
    end
    if (seg !== 7'b1111111) begin
      errors++;
      $display("FAIL rmid_seg got %b exp 1111111", seg);
    end
    if (dp !== 1'b1) begin
      errors++;
      $display("FAIL rmid_dp got %b exp 1", dp);
    end
    reset = 1'b0;
    cyc = 0;
    step();
    checks += 2;
    if (an !== 4'b1110) begin
      errors++;
      $display("FAIL rrel_an got %b exp 1110", an);
    end
    if (seg !== 7'b1000000) begin
      errors++;
      $display("FAIL rrel_seg got %b exp 1000000", seg);
    end
    for (int i = 0; i < 4; i++) step();
    checks += 2;
    if (an !== 4'b1101) begin
      errors++;
      $display("FAIL rrel_an1 got %b exp 1101", an);
    end
    if (seg !== 7'b1111111) begin
      errors++;
      $display("FAIL rrel_seg1 got %b exp 1111111", seg);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midframe();
    test_dp();
    test_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
